// File: rtl/mem_ctrl_pkg.sv
// Shared widths, size codes and state/op encodings for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int unsigned RAM_ADDR_W = 17;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [1:0] {
        SIZE_NONE = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10,
        SIZE_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_FETCH = 2'b10
    } op_e;

    // Number of bytes moved for a size code (0 for SIZE_NONE).
    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        case (code)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller: splits/assembles little-endian loads, stores and fetches over an 8-bit RAM.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_read_req_i,
    input  logic [1:0]        mem_write_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_done_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [BYTE_W-1:0] ram_dout_o,
    input  logic [BYTE_W-1:0] ram_din_i
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          k_q, k_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic                mem_done_q, mem_done_d;
    logic                inst_done_q, inst_done_d;
    logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
    logic                ram_wr_q, ram_wr_d;
    logic [BYTE_W-1:0]   ram_dout_q, ram_dout_d;

    logic [2:0]          k_nxt;
    logic [1:0]          byte_idx;
    logic [DATA_W-1:0]   asm_nxt;

    // State and datapath registers; async reset also kills any in-flight RAM write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOAD;
            base_q      <= '0;
            n_q         <= '0;
            k_q         <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            rdata_q     <= '0;
            inst_q      <= '0;
            mem_done_q  <= 1'b0;
            inst_done_q <= 1'b0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            base_q      <= base_d;
            n_q         <= n_d;
            k_q         <= k_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            rdata_q     <= rdata_d;
            inst_q      <= inst_d;
            mem_done_q  <= mem_done_d;
            inst_done_q <= inst_done_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    // Next state plus the RAM-side outputs for the coming cycle (outputs are registered).
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        base_d      = base_q;
        n_d         = n_q;
        k_d         = k_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        rdata_d     = rdata_q;
        inst_d      = inst_q;
        mem_done_d  = 1'b0;
        inst_done_d = 1'b0;
        ram_a_d     = '0;
        ram_wr_d    = 1'b0;
        ram_dout_d  = '0;
        k_nxt       = k_q + 3'd1;
        byte_idx    = 2'(k_q - 3'd1);
        asm_nxt     = asm_q;

        case (state_q)
            S_IDLE: begin
                if (mem_write_req_i != SIZE_NONE) begin
                    state_d    = S_BUSY;
                    op_d       = OP_STORE;
                    n_d        = size_bytes(mem_write_req_i);
                    base_d     = mem_addr_i;
                    wdata_d    = mem_wdata_i;
                    k_d        = 3'd0;
                    ram_a_d    = mem_addr_i;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = mem_wdata_i[BYTE_W-1:0];
                end else if (mem_read_req_i != SIZE_NONE) begin
                    state_d = S_BUSY;
                    op_d    = OP_LOAD;
                    n_d     = size_bytes(mem_read_req_i);
                    base_d  = mem_addr_i;
                    k_d     = 3'd0;
                    asm_d   = '0;
                    ram_a_d = mem_addr_i;
                end else if (if_req_i) begin
                    state_d = S_BUSY;
                    op_d    = OP_FETCH;
                    n_d     = 3'd4;
                    base_d  = if_addr_i;
                    k_d     = 3'd0;
                    asm_d   = '0;
                    ram_a_d = if_addr_i;
                end
            end

            S_BUSY: begin
                if (op_q == OP_FETCH && !if_req_i) begin
                    // Branch flush: drop the fetch silently.
                    state_d = S_IDLE;
                end else if (op_q == OP_STORE) begin
                    if (k_nxt < n_q) begin
                        k_d        = k_nxt;
                        ram_a_d    = base_q + ADDR_W'(k_nxt);
                        ram_wr_d   = 1'b1;
                        ram_dout_d = BYTE_W'(wdata_q >> {k_nxt, 3'b000});
                    end else begin
                        state_d    = S_DONE;
                        mem_done_d = 1'b1;
                    end
                end else begin
                    // Read data lags its address by one cycle, so cycle k holds byte k-1.
                    if (k_q != 3'd0) begin
                        asm_nxt[{byte_idx, 3'b000} +: BYTE_W] = ram_din_i;
                    end
                    asm_d = asm_nxt;
                    if (k_q == n_q) begin
                        state_d = S_DONE;
                        if (op_q == OP_LOAD) begin
                            rdata_d    = asm_nxt;
                            mem_done_d = 1'b1;
                        end else begin
                            inst_d      = asm_nxt;
                            inst_done_d = 1'b1;
                        end
                    end else begin
                        k_d = k_nxt;
                        if (k_nxt < n_q) begin
                            ram_a_d = base_q + ADDR_W'(k_nxt);
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_rdata_o = rdata_q;
    assign mem_done_o  = mem_done_q;
    assign inst_o      = inst_q;
    assign inst_done_o = inst_done_q;
    assign ram_a_o     = ram_a_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural 128 KiB byte RAM.
module tb_mem_ctrl;

    localparam int unsigned AW   = 17;
    localparam int unsigned LOGN = 16;

    logic          clk;
    logic          rst;
    logic [1:0]    mem_read_req;
    logic [1:0]    mem_write_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_done;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   inst;
    logic          inst_done;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    logic [7:0]    ram [0:(1<<AW)-1];

    int n_checks;
    int n_pass;

    logic [AW-1:0] a_log  [1:LOGN];
    logic          wr_log [1:LOGN];
    int wr_cnt, md_cnt, id_cnt, md_first, id_first;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read_req_i  (mem_read_req),
        .mem_write_req_i (mem_write_req),
        .mem_addr_i      (mem_addr),
        .mem_wdata_i     (mem_wdata),
        .mem_rdata_o     (mem_rdata),
        .mem_done_o      (mem_done),
        .if_req_i        (if_req),
        .if_addr_i       (if_addr),
        .inst_o          (inst),
        .inst_done_o     (inst_done),
        .ram_a_o         (ram_a),
        .ram_wr_o        (ram_wr),
        .ram_dout_o      (ram_dout),
        .ram_din_i       (ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        ram_din <= ram[ram_a];
        if (ram_wr) ram[ram_a] <= ram_dout;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record ncyc cycles following the current point; cycle 1 is the one after the acceptance edge.
    task automatic log_cycles(input int ncyc);
        wr_cnt = 0; md_cnt = 0; id_cnt = 0; md_first = 0; id_first = 0;
        for (int c = 1; c <= ncyc; c++) begin
            a_log[c]  = ram_a;
            wr_log[c] = ram_wr;
            if (ram_wr) wr_cnt++;
            if (mem_done) begin
                md_cnt++;
                if (md_first == 0) md_first = c;
            end
            if (inst_done) begin
                id_cnt++;
                if (id_first == 0) id_first = c;
            end
            tick();
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] v);
        ram[a] <= v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b0;
        mem_read_req = 2'b00; mem_write_req = 2'b00; mem_addr = '0; mem_wdata = '0;
        if_req = 1'b0; if_addr = '0;
        poke(17'h00010, 8'h11); poke(17'h00011, 8'h22);
        poke(17'h00012, 8'h33); poke(17'h00013, 8'h44);
        poke(17'h1FFFF, 8'h00); poke(17'h00000, 8'h00); poke(17'h00001, 8'h5A);
        poke(17'h00100, 8'h80);
        poke(17'h00200, 8'h78); poke(17'h00201, 8'h56);
        poke(17'h00202, 8'h34); poke(17'h00203, 8'h12);
        poke(17'h00004, 8'hAA); poke(17'h00005, 8'hBB);
        poke(17'h00006, 8'hCC); poke(17'h00007, 8'hDD);
        for (int i = 0; i < 4; i++) begin
            poke(17'h00300 + AW'(i), 8'h00);
            poke(17'h00400 + AW'(i), 8'hEE);
        end

        // Reset state
        repeat (2) tick();
        check("rst_ram_wr", 32'(ram_wr), 32'h0);
        check("rst_ram_a", 32'(ram_a), 32'h0);
        check("rst_done", {30'h0, mem_done, inst_done}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        rst = 1'b1;
        tick();

        // Word load at 0x10: four consecutive addresses, done in the 6th cycle
        mem_read_req = 2'b11; mem_addr = 17'h00010;
        tick();
        mem_read_req = 2'b00; mem_addr = 17'h1ABCD;
        log_cycles(8);
        for (int i = 0; i < 4; i++) check("wload_addr", 32'(a_log[i+1]), 32'h10 + 32'(i));
        check("wload_done_lat", 32'(md_first), 32'd6);
        check("wload_done_cnt", 32'(md_cnt), 32'd1);
        check("wload_no_wr", 32'(wr_cnt), 32'd0);
        check("wload_data", mem_rdata, 32'h44332211);

        // Half store at 0x1FFFF wraps to 0x00000; done in the 3rd cycle
        mem_write_req = 2'b10; mem_addr = 17'h1FFFF; mem_wdata = 32'hDEADBEEF;
        tick();
        mem_write_req = 2'b00; mem_wdata = 32'h0;
        log_cycles(6);
        check("hstore_a0", 32'(a_log[1]), 32'h1FFFF);
        check("hstore_a1", 32'(a_log[2]), 32'h00000);
        check("hstore_wr_cnt", 32'(wr_cnt), 32'd2);
        check("hstore_wr_pos", {30'h0, wr_log[1], wr_log[2]}, 32'h3);
        check("hstore_done_lat", 32'(md_first), 32'd3);
        check("hstore_b0", 32'(ram[17'h1FFFF]), 32'hEF);
        check("hstore_b1", 32'(ram[17'h00000]), 32'hBE);
        check("hstore_b2_untouched", 32'(ram[17'h00001]), 32'h5A);
        check("hstore_rdata_hold", mem_rdata, 32'h44332211);

        // Byte load with a concurrent fetch: fetch waits for the data done pulse
        mem_read_req = 2'b01; mem_addr = 17'h00100;
        if_req = 1'b1; if_addr = 17'h00200;
        tick();
        mem_read_req = 2'b00;
        log_cycles(12);
        check("bload_done_lat", 32'(md_first), 32'd3);
        check("bload_data", mem_rdata, 32'h00000080);
        check("fetch_first_addr", 32'(a_log[5]), 32'h200);
        check("fetch_done_lat", 32'(id_first), 32'd10);
        check("fetch_done_cnt", 32'(id_cnt), 32'd1);
        check("fetch_inst", inst, 32'h12345678);
        if_req = 1'b0;
        repeat (3) tick();
        check("fetch_flush_idle", 32'(ram_a), 32'h0);

        // Fetch at 0x4 flushed in BUSY cycle 2: no pulse, instruction unchanged
        if_req = 1'b1; if_addr = 17'h00004;
        tick();
        repeat (2) tick();
        if_req = 1'b0;
        log_cycles(8);
        check("abort_a_busy2", 32'(a_log[1]), 32'h6);
        check("abort_a_idle", 32'(a_log[2]), 32'h0);
        check("abort_no_done", 32'(id_cnt), 32'd0);
        check("abort_inst_hold", inst, 32'h12345678);

        // Store and load codes both word: store wins, no read capture
        mem_write_req = 2'b11; mem_read_req = 2'b11;
        mem_addr = 17'h00300; mem_wdata = 32'hCAFEF00D;
        tick();
        mem_write_req = 2'b00; mem_read_req = 2'b00;
        log_cycles(8);
        check("both_wr_cnt", 32'(wr_cnt), 32'd4);
        check("both_done_lat", 32'(md_first), 32'd5);
        check("both_done_cnt", 32'(md_cnt), 32'd1);
        check("both_mem", {ram[17'h00303], ram[17'h00302], ram[17'h00301], ram[17'h00300]},
              32'hCAFEF00D);
        check("both_rdata_hold", mem_rdata, 32'h00000080);

        // Reset asserted in the 2nd cycle of a word store
        mem_write_req = 2'b11; mem_addr = 17'h00400; mem_wdata = 32'h12345678;
        tick();
        mem_write_req = 2'b00;
        tick();
        check("rstmid_wr_before", 32'(ram_wr), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_wr_now", 32'(ram_wr), 32'h0);
        check("rstmid_a_now", 32'(ram_a), 32'h0);
        check("rstmid_outs_clear", mem_rdata | inst, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("rstmid_b0", 32'(ram[17'h00400]), 32'h78);
        check("rstmid_b1", 32'(ram[17'h00401]), 32'hEE);
        check("rstmid_idle", {14'h0, ram_wr, ram_a}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the pipeline and the 8-bit unified RAM (17-bit byte address). Services data load/store requests from the MEM stage (size-coded `mem_read_req`/`mem_write_req`) and 32-bit instruction fetches from IF. It assembles and splits little-endian bytes and returns a one-cycle completion pulse. The pulse drives MEM's `ram_data_enable_i` and IF's fetch-done.

## Interface
Parameters:
- `ADDR_W`, 17: RAM byte-address width.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_read_req_i`  in  2  data load size: 00 none, 01 byte, 10 half, 11 word.
- `mem_write_req_i`  in  2  data store size, same coding.
- `mem_addr_i`  in  ADDR_W  data base byte address.
- `mem_wdata_i`  in  32  store data; byte 0 = bits 7:0.
- `mem_rdata_o`  out  32  assembled load data, zero-extended; MEM performs sign extension.
- `mem_done_o`  out  1  one-cycle pulse: data transaction complete.
- `if_req_i`  in  1  instruction fetch request.
- `if_addr_i`  in  ADDR_W  fetch address.
- `inst_o`  out  32  fetched instruction.
- `inst_done_o`  out  1  one-cycle pulse: fetch complete.
- `ram_a_o`  out  ADDR_W  RAM byte address.
- `ram_wr_o`  out  1  1 = write `ram_dout_o` to `ram_a_o` this cycle.
- `ram_dout_o`  out  8  RAM write byte.
- `ram_din_i`  in  8  RAM read byte; valid one cycle after its address is presented.

## Operation
- States: IDLE, BUSY, DONE. Registers:
  - latched base, byte count n (1/2/4), op (load/store/fetch);
  - byte counter k (3 bits) and assembly register.
- IDLE → BUSY on an edge where a request is present.
  - Priority: store, then load, then fetch.
  - If both read and write codes are nonzero, the store wins.
  - Base, n, op and write data are latched at acceptance; later input changes are ignored.
- BUSY, cycle k:
  - `ram_a_o` = base + k, wrapping modulo 2^ADDR_W.
  - Store: `ram_wr_o`=1, `ram_dout_o` = write-data byte k, for k = 0..n-1, then DONE.
  - Load/fetch: address issued for k = 0..n-1. Byte k is captured from `ram_din_i` at the end of cycle k+1 into assembly bits [8k+7:8k]. Go to DONE after capturing byte n-1 (cycle n).
  - Unused upper bytes are 0.
- DONE (1 cycle):
  - Pulse `mem_done_o` (load/store) or `inst_done_o` (fetch).
  - Load: `mem_rdata_o` updated; fetch: `inst_o` updated.
  - Both outputs hold their value until the next completion of their own kind.
  - Return to IDLE.
- Fetch abort: if `if_req_i` is low in any BUSY cycle of a fetch (branch flush), go straight to IDLE. No done pulse; `inst_o` unchanged.
- Data transactions are never aborted.
- `ram_wr_o`=0 in every state except BUSY-store. `ram_a_o`=0 and `ram_dout_o`=0 in IDLE/DONE.

## Timing
- Reset (asynchronous assertion): state=IDLE; `ram_wr_o`=0, `ram_a_o`=0, `ram_dout_o`=0, `mem_done_o`=0, `inst_done_o`=0, `mem_rdata_o`=0, `inst_o`=0. This takes effect mid-transaction without waiting for a clock, so no partial write continues after reset.
- Latency, from the acceptance edge to the done pulse:
  - store: n+1 cycles (n write cycles, then DONE);
  - load/fetch: n+2 cycles (word: 6).
- Requester contract: MEM drops a store request in the done cycle. A request still present in IDLE after DONE is treated as a new transaction.
- Back-to-back: IDLE is always entered for at least one cycle between transactions. Minimum spacing is therefore a single idle cycle.
- A fetch pending during a data transaction waits; it is accepted at the first IDLE edge with no data request.

## Structure
- In `define.v`:
  - size codes (SIZE_NONE/BYTE/HALF/WORD);
  - state encodings;
  - `RamAddrBus` width 17.
- No sub-module: single FSM with datapath registers.

## Test plan
- Word load, addr 0x00010, RAM bytes 11 22 33 44 → `ram_a_o` 0x10..0x13 on consecutive cycles; `mem_done_o` pulse 6 cycles after acceptance; `mem_rdata_o`=0x44332211.
- Half store, data 0xDEADBEEF at 0x1FFFF → writes EF@0x1FFFF then BE@0x00000 (wrap); `ram_wr_o` high exactly 2 cycles; done 3 cycles after acceptance.
- Byte load 0x80 → `mem_rdata_o`=0x00000080; simultaneous `if_req_i` is served only after the data done pulse.
- Fetch at 0x00004, `if_req_i` dropped in BUSY cycle 2 → IDLE next edge; no `inst_done_o`; `inst_o` keeps its old value.
- `rst` low during the 2nd cycle of a word store → `ram_wr_o`=0 immediately; only byte 0 written; state IDLE after release.
- Store and load codes both 11 → store performed; no read data captured.
